// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared widths and state encoding for the icache miss-fetch responder
package fetch_ctrl_pkg;

  localparam int PcLength      = 31;
  localparam int DataLength    = 31;
  localparam int RamDataLength = 7;

  localparam int BytesPerWord  = 4;
  localparam int CntWidth      = $clog2(BytesPerWord);

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_READ  = 2'd1,
    FC_DRAIN = 2'd2
  } fc_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - serves icache miss fetches as four little-endian byte reads from RAM
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PcLength:0]      addr_from_ic,
  input  logic                   is_empty_from_ic,
  input  logic                   is_exception_from_rob,
  input  logic [RamDataLength:0] mem_din_from_ram,
  output logic [31:0]            addr_to_ram,
  output logic                   is_write_to_ram,
  output logic [DataLength:0]    instr_to_ic,
  output logic                   is_instr_to_ic,
  output logic                   is_commit_to_ic
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(BytesPerWord - 1);

  fc_state_e                                state, state_nxt;
  logic [CntWidth-1:0]                      cnt, cnt_nxt;
  logic [BytesPerWord-2:0][RamDataLength:0] bytes, bytes_nxt;
  logic [31:0]                              addr_nxt;
  logic [DataLength:0]                      instr_nxt;
  logic                                     pulse_nxt;

  // The RAM is only ever read from this port.
  assign is_write_to_ram = False;
  assign is_commit_to_ic = is_instr_to_ic;

  // Next-state and datapath decisions; the flush takes priority over every state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bytes_nxt = bytes;
    addr_nxt  = addr_to_ram;
    instr_nxt = instr_to_ic;
    pulse_nxt = False;
    if (is_exception_from_rob) begin
      state_nxt = FC_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        FC_IDLE: begin
          if (!is_empty_from_ic) begin
            addr_nxt  = addr_from_ic;
            cnt_nxt   = '0;
            state_nxt = FC_READ;
          end
        end
        FC_READ: begin
          // Data lags the address by one cycle, so the byte arriving now belongs to cnt-1.
          if (cnt != '0) begin
            bytes_nxt[cnt - 1'b1] = mem_din_from_ram;
          end
          if (cnt == CntLast) begin
            state_nxt = FC_DRAIN;
          end else begin
            addr_nxt = addr_to_ram + 32'd1;
            cnt_nxt  = cnt + 1'b1;
          end
        end
        FC_DRAIN: begin
          instr_nxt = {mem_din_from_ram, bytes[2], bytes[1], bytes[0]};
          pulse_nxt = True;
          state_nxt = FC_IDLE;
        end
        default: begin
          state_nxt = FC_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register and registered outputs; reset drops any transfer without a pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= FC_IDLE;
      cnt            <= '0;
      bytes          <= '0;
      addr_to_ram    <= '0;
      instr_to_ic    <= '0;
      is_instr_to_ic <= False;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bytes          <= bytes_nxt;
      addr_to_ram    <= addr_nxt;
      instr_to_ic    <= instr_nxt;
      is_instr_to_ic <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vectors and corner sequences for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_from_ic;
  logic        is_empty_from_ic;
  logic        is_exception_from_rob;
  logic [7:0]  mem_din_from_ram;
  logic [31:0] addr_to_ram;
  logic        is_write_to_ram;
  logic [31:0] instr_to_ic;
  logic        is_instr_to_ic;
  logic        is_commit_to_ic;

  int checks = 0;
  int errors = 0;
  logic write_seen = 1'b0;

  logic [7:0] mem [logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [4];

  fetch_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .addr_from_ic          (addr_from_ic),
    .is_empty_from_ic      (is_empty_from_ic),
    .is_exception_from_rob (is_exception_from_rob),
    .mem_din_from_ram      (mem_din_from_ram),
    .addr_to_ram           (addr_to_ram),
    .is_write_to_ram       (is_write_to_ram),
    .instr_to_ic           (instr_to_ic),
    .is_instr_to_ic        (is_instr_to_ic),
    .is_commit_to_ic       (is_commit_to_ic)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // One-cycle read latency RAM model
  always @(posedge clk) mem_din_from_ram <= rd(addr_to_ram);

  always @(negedge clk) if (is_write_to_ram !== 1'b0) write_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] a, input logic [7:0] b0, b1, b2, b3);
    mem[a]         = b0;
    mem[a + 32'd1] = b1;
    mem[a + 32'd2] = b2;
    mem[a + 32'd3] = b3;
  endtask

  task automatic idle_no_pulse(input int n, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (is_instr_to_ic || is_commit_to_ic) seen = 1'b1;
    end
    check(name, {31'b0, seen}, 32'd0);
  endtask

  // Full fetch from IDLE: request at E0, addresses after E0..E3, pulse after E5
  task automatic do_fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic early;
    early = 1'b0;
    addr_from_ic     = a;
    is_empty_from_ic = 1'b0;
    tick();
    is_empty_from_ic = 1'b1;
    check({name, " addr0"}, addr_to_ram, a);
    for (int k = 1; k < 4; k++) begin
      tick();
      if (is_instr_to_ic) early = 1'b1;
      check($sformatf("%s addr%0d", name, k), addr_to_ram, a + 32'(k));
    end
    tick();
    if (is_instr_to_ic) early = 1'b1;
    check({name, " no early pulse"}, {31'b0, early}, 32'd0);
    tick();
    check({name, " instr pulse"}, {30'b0, is_instr_to_ic, is_commit_to_ic}, 32'd3);
    check({name, " instr"}, instr_to_ic, exp);
    tick();
    check({name, " pulse one cycle"}, {30'b0, is_instr_to_ic, is_commit_to_ic}, 32'd0);
    check({name, " instr held"}, instr_to_ic, exp);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 8'h13, 8'h05, 8'h00, 8'h00, 32'h0000_0513};
    vecs[1] = '{32'hFFFF_FFFE, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCC_BBAA};
    vecs[2] = '{32'h0000_0007, 8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201};
    vecs[3] = '{32'h8000_0000, 8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF_00FF};

    rst                   = 1'b0;
    addr_from_ic          = 32'h0;
    is_empty_from_ic      = 1'b1;
    is_exception_from_rob = 1'b0;
    repeat (3) tick();
    check("reset addr", addr_to_ram, 32'h0);
    check("reset instr", instr_to_ic, 32'h0);
    check("reset pulses", {30'b0, is_instr_to_ic, is_commit_to_ic}, 32'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      load_word(vecs[i].addr, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_instr);
    end

    // Request held low throughout: only 0x2000 served, then 0x2004 accepted at the pulse edge
    load_word(32'h2000, 8'h11, 8'h22, 8'h33, 8'h44);
    load_word(32'h2004, 8'h55, 8'h66, 8'h77, 8'h88);
    addr_from_ic     = 32'h2000;
    is_empty_from_ic = 1'b0;
    tick();
    addr_from_ic = 32'h2004;
    check("held addr0", addr_to_ram, 32'h2000);
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("held addr%0d", k), addr_to_ram, 32'h2000 + 32'(k));
    end
    tick();
    tick();
    check("held pulse", {31'b0, is_instr_to_ic}, 32'd1);
    check("held instr", instr_to_ic, 32'h4433_2211);
    check("held ignored in drain", addr_to_ram, 32'h2003);
    tick();
    is_empty_from_ic = 1'b1;
    check("held next accept", addr_to_ram, 32'h2004);
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("held2 addr%0d", k), addr_to_ram, 32'h2004 + 32'(k));
    end
    tick();
    tick();
    check("held2 pulse", {31'b0, is_instr_to_ic}, 32'd1);
    check("held2 instr", instr_to_ic, 32'h8877_6655);

    // Exception at E3 aborts the fetch of 0x3000
    load_word(32'h3000, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    load_word(32'h3004, 8'h21, 8'h43, 8'h65, 8'h87);
    addr_from_ic     = 32'h3000;
    is_empty_from_ic = 1'b0;
    tick();
    is_empty_from_ic = 1'b1;
    tick();
    tick();
    is_exception_from_rob = 1'b1;
    tick();
    is_exception_from_rob = 1'b0;
    check("exc addr frozen", addr_to_ram, 32'h3002);
    idle_no_pulse(8, "exc no pulse");
    check("exc idle addr held", addr_to_ram, 32'h3002);
    do_fetch("after exc", 32'h3004, 32'h8765_4321);

    // Exception and request on the same edge: request dropped
    addr_from_ic          = 32'h4000;
    is_empty_from_ic      = 1'b0;
    is_exception_from_rob = 1'b1;
    tick();
    is_empty_from_ic      = 1'b1;
    is_exception_from_rob = 1'b0;
    check("exc+req addr", addr_to_ram, 32'h3007);
    idle_no_pulse(10, "exc+req no pulse");
    check("exc+req addr held", addr_to_ram, 32'h3007);

    // Reset during READ with cnt==2
    addr_from_ic     = 32'h6000;
    is_empty_from_ic = 1'b0;
    tick();
    is_empty_from_ic = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid rst addr", addr_to_ram, 32'h0);
    check("mid rst instr", instr_to_ic, 32'h0);
    check("mid rst pulses", {30'b0, is_instr_to_ic, is_commit_to_ic}, 32'd0);
    idle_no_pulse(6, "mid rst no pulse");
    load_word(32'h6010, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    do_fetch("after rst", 32'h6010, 32'hF0DE_BC9A);

    check("write enable low", {31'b0, write_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
